// File: rtl/shifter_timing_pkg.sv
// ---------------------------------------------------------------------------
// shifter_timing_pkg
// Shared timing constants for the ST shifter video controller.
// Holds the default 50 Hz / 60 Hz raster geometry, the 16-clock fetch/load
// slot length, the number of words per active line, the counter widths and
// the default video word-address width.
// No ports (package).
// ---------------------------------------------------------------------------
package shifter_timing_pkg;

    // Raster geometry, in CLOCK_32 cycles (horizontal) and lines (vertical)
    localparam int DEF_H_TOTAL_50    = 2048;
    localparam int DEF_H_TOTAL_60    = 2032;
    localparam int DEF_V_TOTAL_50    = 313;
    localparam int DEF_V_TOTAL_60    = 263;
    localparam int DEF_H_DE_START    = 448;
    localparam int DEF_H_DE_LEN      = 1280;
    localparam int DEF_V_DE_START_50 = 63;
    localparam int DEF_V_DE_START_60 = 34;
    localparam int DEF_V_DE_LEN      = 200;
    localparam int DEF_H_SYNC_START  = 0;
    localparam int DEF_H_SYNC_LEN    = 150;
    localparam int DEF_V_SYNC_START  = 0;
    localparam int DEF_V_SYNC_LEN    = 3;
    localparam int DEF_LOAD_OFFSET   = 8;

    // One four-plane word is fetched and loaded every 16 clocks
    localparam int DEF_SLOT_LEN       = 16;
    localparam int DEF_WORDS_PER_LINE = 80;
    localparam int SLOT_W             = $clog2(DEF_SLOT_LEN);

    // Video word-address width
    localparam int DEF_AW = 22;

    // Counter widths, wide enough for the longest line and frame
    localparam int H_CNT_W = 12;
    localparam int V_CNT_W = 10;

endpackage

// File: rtl/shifter_raster_counter.sv
// ---------------------------------------------------------------------------
// shifter_raster_counter
// Horizontal / vertical raster position counters with a mode-dependent wrap.
// The 50/60 Hz mode is latched only at frame position (0,0), so a mode change
// first affects the length of line 0 of the following frame.
//
// Ports:
//   i_clock      - CLOCK_32
//   i_reset      - synchronous, active-high reset
//   i_sync60hz   - requested mode (1 = 60 Hz), sampled at frame start
//   o_h          - horizontal position, 0..HT-1
//   o_v          - vertical position, 0..VT-1
//   o_mode60     - mode currently in effect
//   o_atOrigin   - high while the counters sit at (0,0)
// ---------------------------------------------------------------------------
module shifter_raster_counter
    import shifter_timing_pkg::*;
#(
    parameter int H_TOTAL_50 = DEF_H_TOTAL_50,
    parameter int H_TOTAL_60 = DEF_H_TOTAL_60,
    parameter int V_TOTAL_50 = DEF_V_TOTAL_50,
    parameter int V_TOTAL_60 = DEF_V_TOTAL_60
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_sync60hz,
    output logic [H_CNT_W-1:0] o_h,
    output logic [V_CNT_W-1:0] o_v,
    output logic               o_mode60,
    output logic               o_atOrigin
);

    localparam logic [H_CNT_W-1:0] C_HLAST_50 = H_CNT_W'(H_TOTAL_50 - 1);
    localparam logic [H_CNT_W-1:0] C_HLAST_60 = H_CNT_W'(H_TOTAL_60 - 1);
    localparam logic [V_CNT_W-1:0] C_VLAST_50 = V_CNT_W'(V_TOTAL_50 - 1);
    localparam logic [V_CNT_W-1:0] C_VLAST_60 = V_CNT_W'(V_TOTAL_60 - 1);

    logic [H_CNT_W-1:0] r_h;
    logic [V_CNT_W-1:0] r_v;
    logic               r_mode60;
    logic               w_hLast;
    logic               w_vLast;
    logic               w_atOrigin;

    // End-of-line / end-of-frame detection uses the latched mode, so the
    // frame that is in progress always finishes with its own geometry.
    always_comb begin
        w_hLast    = (r_h == (r_mode60 ? C_HLAST_60 : C_HLAST_50));
        w_vLast    = (r_v == (r_mode60 ? C_VLAST_60 : C_VLAST_50));
        w_atOrigin = (r_h == '0) && (r_v == '0);
    end

    // Position counters and mode latch. The mode is picked up while the
    // counters sit at (0,0); the first wrap compare that can see the new
    // value is the end of line 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_h      <= '0;
            r_v      <= '0;
            r_mode60 <= 1'b0;
        end else begin
            if (w_atOrigin) begin
                r_mode60 <= i_sync60hz;
            end
            if (w_hLast) begin
                r_h <= '0;
                r_v <= w_vLast ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign o_h        = r_h;
    assign o_v        = r_v;
    assign o_mode60   = r_mode60;
    assign o_atOrigin = w_atOrigin;

endmodule

// File: rtl/shifter_video_ctrl.sv
// ---------------------------------------------------------------------------
// shifter_video_ctrl
// Video timing controller for the ST shifter. Derives display enable, the
// per-slot memory fetch and shifter load strobes, the video word address,
// both syncs and a frame-start pulse from the raster position. Every output
// is a registered decode of the previous cycle's (h,v).
//
// Ports:
//   CLOCK_32    - 32 MHz system clock
//   reset       - synchronous, active-high reset
//   sync_60hz   - mode select (1 = 60 Hz), sampled at frame start
//   vbase       - screen base word address, sampled at frame start
//   de          - display enable to the shifter
//   load        - one-clock shifter load strobe
//   fetch       - one-clock memory read request, vaddr valid with it
//   vaddr       - current video word address
//   hsync_n     - horizontal sync, active low
//   vsync_n     - vertical sync, active low
//   frame_start - one-clock pulse for frame position (0,0)
// ---------------------------------------------------------------------------
module shifter_video_ctrl
    import shifter_timing_pkg::*;
#(
    parameter int H_TOTAL_50    = DEF_H_TOTAL_50,
    parameter int H_TOTAL_60    = DEF_H_TOTAL_60,
    parameter int V_TOTAL_50    = DEF_V_TOTAL_50,
    parameter int V_TOTAL_60    = DEF_V_TOTAL_60,
    parameter int H_DE_START    = DEF_H_DE_START,
    parameter int H_DE_LEN      = DEF_H_DE_LEN,
    parameter int V_DE_START_50 = DEF_V_DE_START_50,
    parameter int V_DE_START_60 = DEF_V_DE_START_60,
    parameter int V_DE_LEN      = DEF_V_DE_LEN,
    parameter int H_SYNC_START  = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN    = DEF_H_SYNC_LEN,
    parameter int V_SYNC_START  = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN    = DEF_V_SYNC_LEN,
    parameter int LOAD_OFFSET   = DEF_LOAD_OFFSET,
    parameter int AW            = DEF_AW
) (
    input  logic          CLOCK_32,
    input  logic          reset,
    input  logic          sync_60hz,
    input  logic [AW-1:0] vbase,
    output logic          de,
    output logic          load,
    output logic          fetch,
    output logic [AW-1:0] vaddr,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          frame_start
);

    localparam logic [H_CNT_W-1:0] C_HDS    = H_CNT_W'(H_DE_START);
    localparam logic [H_CNT_W-1:0] C_HDL    = H_CNT_W'(H_DE_LEN);
    localparam logic [H_CNT_W-1:0] C_HSS    = H_CNT_W'(H_SYNC_START);
    localparam logic [H_CNT_W-1:0] C_HSL    = H_CNT_W'(H_SYNC_LEN);
    localparam logic [V_CNT_W-1:0] C_VDS_50 = V_CNT_W'(V_DE_START_50);
    localparam logic [V_CNT_W-1:0] C_VDS_60 = V_CNT_W'(V_DE_START_60);
    localparam logic [V_CNT_W-1:0] C_VDL    = V_CNT_W'(V_DE_LEN);
    localparam logic [V_CNT_W-1:0] C_VSS    = V_CNT_W'(V_SYNC_START);
    localparam logic [V_CNT_W-1:0] C_VSL    = V_CNT_W'(V_SYNC_LEN);
    localparam logic [SLOT_W-1:0]  C_LOAD   = SLOT_W'(LOAD_OFFSET);

    logic [H_CNT_W-1:0] w_h;
    logic [V_CNT_W-1:0] w_v;
    logic               w_mode60;
    logic               w_atOrigin;

    logic [H_CNT_W-1:0] w_hDeOff;
    logic [V_CNT_W-1:0] w_vDeOff;
    logic [V_CNT_W-1:0] w_vds;
    logic [SLOT_W-1:0]  w_phase;
    logic               w_de;
    logic               w_fetch;
    logic               w_load;
    logic               w_hSync;
    logic               w_vSync;

    logic               r_de;
    logic               r_load;
    logic               r_fetch;
    logic [AW-1:0]      r_vaddr;
    logic               r_hsyncN;
    logic               r_vsyncN;
    logic               r_frameStart;

    shifter_raster_counter #(
        .H_TOTAL_50 (H_TOTAL_50),
        .H_TOTAL_60 (H_TOTAL_60),
        .V_TOTAL_50 (V_TOTAL_50),
        .V_TOTAL_60 (V_TOTAL_60)
    ) u_rasterCounter (
        .i_clock    (CLOCK_32),
        .i_reset    (reset),
        .i_sync60hz (sync_60hz),
        .o_h        (w_h),
        .o_v        (w_v),
        .o_mode60   (w_mode60),
        .o_atOrigin (w_atOrigin)
    );

    // Window and sync decode. Each range test subtracts the start and
    // compares against the length: positions before the start wrap to a
    // large unsigned value and fall outside, which also keeps a start of 0
    // from turning into an always-true compare. The low bits of the
    // horizontal offset are the slot phase, so slots stay aligned to the
    // window start whatever H_DE_START is.
    always_comb begin
        w_hDeOff = w_h - C_HDS;
        w_vds    = w_mode60 ? C_VDS_60 : C_VDS_50;
        w_vDeOff = w_v - w_vds;
        w_phase  = w_hDeOff[SLOT_W-1:0];
        w_de     = (w_hDeOff < C_HDL) && (w_vDeOff < C_VDL);
        w_fetch  = w_de && (w_phase == '0);
        w_load   = w_de && (w_phase == C_LOAD);
        w_hSync  = (w_h - C_HSS) < C_HSL;
        w_vSync  = (w_v - C_VSS) < C_VSL;
    end

    // Output registers. The address register reloads from vbase at (0,0)
    // and otherwise steps once in the cycle after each fetch, so the value
    // on vaddr while fetch is high is the word being requested. The address
    // runs on across lines, giving contiguous 160-byte lines. Reset clears
    // every strobe at once, so a slot in flight is simply abandoned.
    always_ff @(posedge CLOCK_32) begin
        if (reset) begin
            r_de         <= 1'b0;
            r_load       <= 1'b0;
            r_fetch      <= 1'b0;
            r_vaddr      <= '0;
            r_hsyncN     <= 1'b1;
            r_vsyncN     <= 1'b1;
            r_frameStart <= 1'b0;
        end else begin
            r_de         <= w_de;
            r_load       <= w_load;
            r_fetch      <= w_fetch;
            r_hsyncN     <= ~w_hSync;
            r_vsyncN     <= ~w_vSync;
            r_frameStart <= w_atOrigin;
            if (w_atOrigin) begin
                r_vaddr <= vbase;
            end else if (r_fetch) begin
                r_vaddr <= r_vaddr + 1'b1;
            end
        end
    end

    assign de          = r_de;
    assign load        = r_load;
    assign fetch       = r_fetch;
    assign vaddr       = r_vaddr;
    assign hsync_n     = r_hsyncN;
    assign vsync_n     = r_vsyncN;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_shifter_video_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shifter_video_ctrl
// Directed bench for shifter_video_ctrl, run on a scaled-down raster so that
// several complete frames fit in a short run. Expected values are written
// from the scaled geometry below.
// ---------------------------------------------------------------------------
module tb_shifter_video_ctrl;

    // Scaled raster used for this bench
    localparam int HT50    = 160;
    localparam int HT60    = 144;
    localparam int VT50    = 12;
    localparam int VT60    = 10;
    localparam int HDS     = 48;
    localparam int HDL     = 64;
    localparam int VDS50   = 4;
    localparam int VDS60   = 3;
    localparam int VDL     = 5;
    localparam int HSL     = 20;
    localparam int VSL     = 2;
    localparam int LOADOFF = 8;
    localparam int SLOT    = 16;
    localparam int AW      = 22;
    localparam int WPL     = HDL / SLOT;
    localparam int FRAME_BUDGET = 4000;

    logic          clock = 1'b0;
    logic          reset;
    logic          sync60hz;
    logic [AW-1:0] vbase;
    logic          de;
    logic          load;
    logic          fetch;
    logic [AW-1:0] vaddr;
    logic          hsyncN;
    logic          vsyncN;
    logic          frameStart;

    int vectors     = 0;
    int miscompares = 0;

    shifter_video_ctrl #(
        .H_TOTAL_50    (HT50),
        .H_TOTAL_60    (HT60),
        .V_TOTAL_50    (VT50),
        .V_TOTAL_60    (VT60),
        .H_DE_START    (HDS),
        .H_DE_LEN      (HDL),
        .V_DE_START_50 (VDS50),
        .V_DE_START_60 (VDS60),
        .V_DE_LEN      (VDL),
        .H_SYNC_START  (0),
        .H_SYNC_LEN    (HSL),
        .V_SYNC_START  (0),
        .V_SYNC_LEN    (VSL),
        .LOAD_OFFSET   (LOADOFF),
        .AW            (AW)
    ) dut (
        .CLOCK_32    (clock),
        .reset       (reset),
        .sync_60hz   (sync60hz),
        .vbase       (vbase),
        .de          (de),
        .load        (load),
        .fetch       (fetch),
        .vaddr       (vaddr),
        .hsync_n     (hsyncN),
        .vsync_n     (vsyncN),
        .frame_start (frameStart)
    );

    // Free-running CLOCK_32 stand-in
    always #5 clock = ~clock;

    // Drive all DUT inputs at once
    task automatic applyStimulus(input logic rst, input logic s60, input logic [AW-1:0] base);
        reset    = rst;
        sync60hz = s60;
        vbase    = base;
    endtask

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Walk one frame starting at the cycle where frame_start is visible and
    // stop at the next frame_start. Optionally change inputs mid-frame.
    task automatic measureFrame(input string name, input int ht, input int vt, input int vds,
                                input logic [AW-1:0] expBase, input int changeAt,
                                input logic newSync, input logic [AW-1:0] newBase);
        int idx = 0;
        int deTotal = 0;
        int deRuns = 0;
        int deBadRuns = 0;
        int curRun = 0;
        int firstDe = -1;
        int fetches = 0;
        int loads = 0;
        int stray = 0;
        int lagErrs = 0;
        int gapErrs = 0;
        int addrErrs = 0;
        int hsLow = 0;
        int hsRun = 0;
        int hsMaxRun = 0;
        int vsLow = 0;
        int lastFetch = -1000;
        int lastFetchRun = -1;
        bit done = 1'b0;
        logic [AW-1:0] firstAddr = '1;
        while (!done) begin
            if (de) begin
                if (curRun == 0) begin
                    deRuns++;
                    if (firstDe < 0) firstDe = idx;
                end
                curRun++;
                deTotal++;
            end else begin
                if (curRun != 0 && curRun != HDL) deBadRuns++;
                curRun = 0;
            end
            if (fetch) begin
                if (!de) stray++;
                if (lastFetchRun == deRuns && (idx - lastFetch) != SLOT) gapErrs++;
                if (vaddr !== expBase + AW'(fetches)) addrErrs++;
                if (fetches == 0) firstAddr = vaddr;
                fetches++;
                lastFetch    = idx;
                lastFetchRun = deRuns;
            end
            if (load) begin
                if (!de) stray++;
                if ((idx - lastFetch) != LOADOFF) lagErrs++;
                loads++;
            end
            if (!hsyncN) begin
                hsLow++;
                hsRun++;
                if (hsRun > hsMaxRun) hsMaxRun = hsRun;
            end else begin
                hsRun = 0;
            end
            if (!vsyncN) vsLow++;
            if (idx == changeAt) applyStimulus(1'b0, newSync, newBase);
            @(negedge clock);
            idx++;
            if (frameStart || idx > FRAME_BUDGET) done = 1'b1;
        end
        checkOutput($sformatf("%s.frame_len", name), idx, ht * vt);
        checkOutput($sformatf("%s.de_total", name), deTotal, VDL * HDL);
        checkOutput($sformatf("%s.de_runs", name), deRuns, VDL);
        checkOutput($sformatf("%s.de_bad_runs", name), deBadRuns, 0);
        checkOutput($sformatf("%s.first_de", name), firstDe, vds * ht + HDS);
        checkOutput($sformatf("%s.fetches", name), fetches, VDL * WPL);
        checkOutput($sformatf("%s.loads", name), loads, VDL * WPL);
        checkOutput($sformatf("%s.stray_strobes", name), stray, 0);
        checkOutput($sformatf("%s.load_lag_errs", name), lagErrs, 0);
        checkOutput($sformatf("%s.fetch_gap_errs", name), gapErrs, 0);
        checkOutput($sformatf("%s.addr_errs", name), addrErrs, 0);
        checkOutput($sformatf("%s.first_addr", name), firstAddr, expBase);
        checkOutput($sformatf("%s.hsync_low", name), hsLow, HSL * vt);
        checkOutput($sformatf("%s.hsync_run", name), hsMaxRun, HSL);
        checkOutput($sformatf("%s.vsync_low", name), vsLow, VSL * ht);
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b0, 22'h3FFFFF);
        repeat (3) @(negedge clock);
        checkOutput("reset.strobes", {de, load, fetch, frameStart}, 4'b0000);
        checkOutput("reset.syncs", {hsyncN, vsyncN}, 2'b11);
        checkOutput("reset.vaddr", vaddr, 0);

        // Release: frame_start on the second cycle, vaddr loaded from vbase
        applyStimulus(1'b0, 1'b0, 22'h010000);
        @(negedge clock);
        checkOutput("release.frame_start", frameStart, 1);
        checkOutput("release.hsync_n", hsyncN, 0);
        checkOutput("release.vaddr", vaddr, 22'h010000);

        // Frame 1, 50 Hz
        measureFrame("f1_50", HT50, VT50, VDS50, 22'h010000, -1, 1'b0, 22'h010000);
        checkOutput("f2.reload_vaddr", vaddr, 22'h010000);

        // Frame 2, 50 Hz; switch to 60 Hz and a new base mid-frame
        measureFrame("f2_50", HT50, VT50, VDS50, 22'h010000, 1000, 1'b1, 22'h020000);
        checkOutput("f3.reload_vaddr", vaddr, 22'h020000);

        // Frame 3 runs at 60 Hz from the new base
        measureFrame("f3_60", HT60, VT60, VDS60, 22'h020000, -1, 1'b1, 22'h020000);

        // Frame 4: reset at slot phase 4 of the first active line
        repeat (VDS60 * HT60 + HDS + 4) @(negedge clock);
        checkOutput("prereset.de", de, 1);
        applyStimulus(1'b1, 1'b1, 22'h030000);
        @(negedge clock);
        checkOutput("midreset.strobes", {de, load, fetch, frameStart}, 4'b0000);
        checkOutput("midreset.vaddr", vaddr, 0);
        checkOutput("midreset.syncs", {hsyncN, vsyncN}, 2'b11);
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 22'h030000);
        @(negedge clock);
        checkOutput("rerelease.frame_start", frameStart, 1);
        checkOutput("rerelease.vaddr", vaddr, 22'h030000);
        measureFrame("f5_60", HT60, VT60, VDS60, 22'h030000, -1, 1'b1, 22'h030000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
